// File: rtl/agen_stage.sv
`default_nettype none
// ============================================================================
// Module   : agen_stage
// Purpose  : Address-generation stage of the memory issue lane. Forms the
//            effective address (base + sign-extended immediate), flags
//            misaligned accesses, and registers the packet into a single
//            output stage backed by a one-entry skid buffer so that LSU
//            backpressure never drops a packet. Packets are squashed on a
//            branch mispredict and have mask bits cleared on a correct
//            resolve.
// Ports    : clk, reset (sync, active-high)
//            ctrlMispredict_i/ctrlResolve_i/ctrlSMTid_i : branch control
//            issue*_i / issueReady_o                     : issue side
//            lsuReady_i / agen*_o                        : LSU side
// Config   : `define AGEN_MISALIGN_TRAP_EN to enable the misalign flag;
//            otherwise agenMisalign_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module agen_stage #(
  parameter int SIZE_DATA           = 32,
  parameter int SIZE_IMM            = 16,
  parameter int CHECKPOINTS         = 8,
  parameter int CHECKPOINTS_LOG     = 3,
  parameter int SIZE_LSQ_LOG        = 5,
  parameter int SIZE_ACTIVELIST_LOG = 7,
  parameter int SIZE_PHYSICAL_LOG   = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ctrlMispredict_i,
  input  logic                           ctrlResolve_i,
  input  logic [CHECKPOINTS_LOG-1:0]     ctrlSMTid_i,
  input  logic                           issueValid_i,
  output logic                           issueReady_o,
  input  logic [CHECKPOINTS-1:0]         issueMask_i,
  input  logic [2:0]                     issueType_i,
  input  logic [SIZE_DATA-1:0]           issueBase_i,
  input  logic [SIZE_IMM-1:0]            issueImm_i,
  input  logic [SIZE_DATA-1:0]           issueStData_i,
  input  logic [SIZE_LSQ_LOG-1:0]        issueLsqId_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] issueAlId_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]   issuePhyDest_i,
  input  logic                           lsuReady_i,
  output logic                           agenValid_o,
  output logic [CHECKPOINTS-1:0]         agenMask_o,
  output logic [2:0]                     agenType_o,
  output logic [SIZE_DATA-1:0]           agenAddr_o,
  output logic [SIZE_DATA-1:0]           agenStData_o,
  output logic [SIZE_LSQ_LOG-1:0]        agenLsqId_o,
  output logic [SIZE_ACTIVELIST_LOG-1:0] agenAlId_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]   agenPhyDest_o,
  output logic                           agenMisalign_o
);

  // Packet payload (everything except valid and branch mask), packed as
  // {type, addr, stData, lsqId, alId, phyDest, misalign}.
  localparam int PKT_W = 3 + 2*SIZE_DATA + SIZE_LSQ_LOG + SIZE_ACTIVELIST_LOG
                         + SIZE_PHYSICAL_LOG + 1;

  logic                   r_outValid;
  logic [CHECKPOINTS-1:0] r_outMask;
  logic [PKT_W-1:0]       r_outPkt;
  logic                   r_skidValid;
  logic [CHECKPOINTS-1:0] r_skidMask;
  logic [PKT_W-1:0]       r_skidPkt;

  logic [SIZE_DATA-1:0]   w_addr;
  logic                   w_misalign;
  logic                   w_resolve;
  logic [CHECKPOINTS-1:0] w_clrMask;
  logic                   w_inKill;
  logic                   w_outKill;
  logic                   w_skidKill;
  logic                   w_inValid;
  logic                   w_advance;
  logic [CHECKPOINTS-1:0] w_inMask;
  logic [PKT_W-1:0]       w_inPkt;

  assign w_addr = issueBase_i +
                  {{(SIZE_DATA-SIZE_IMM){issueImm_i[SIZE_IMM-1]}}, issueImm_i};

`ifdef AGEN_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (issueType_i[1:0])
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = w_addr[0];
      2'd2:    w_misalign = |w_addr[1:0];
      default: w_misalign = 1'b1;     // reserved size always faults
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Mispredict takes priority: a resolve in the same cycle is ignored.
  assign w_resolve  = ctrlResolve_i & ~ctrlMispredict_i;
  assign w_clrMask  = w_resolve ? (CHECKPOINTS'(1) << ctrlSMTid_i) : '0;

  assign w_inKill   = ctrlMispredict_i & issueMask_i[ctrlSMTid_i];
  assign w_outKill  = ctrlMispredict_i & r_outMask[ctrlSMTid_i];
  assign w_skidKill = ctrlMispredict_i & r_skidMask[ctrlSMTid_i];

  assign issueReady_o = ~r_skidValid;
  assign w_inValid    = issueValid_i & issueReady_o & ~w_inKill;
  assign w_inMask     = issueMask_i & ~w_clrMask;
  assign w_inPkt      = {issueType_i, w_addr, issueStData_i, issueLsqId_i,
                         issueAlId_i, issuePhyDest_i, w_misalign};

  // A squashed output slot is free to refill on the same edge.
  assign agenValid_o = r_outValid & ~w_outKill;
  assign w_advance   = ~agenValid_o | lsuReady_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outValid  <= 1'b0;
      r_outMask   <= '0;
      r_outPkt    <= '0;
      r_skidValid <= 1'b0;
      r_skidMask  <= '0;
      r_skidPkt   <= '0;
    end else if (w_advance) begin
      if (r_skidValid) begin
        // Skid entry is older than anything on the issue side; it goes
        // first. No new packet can be accepted while the skid is full.
        r_outValid  <= ~w_skidKill;
        r_outMask   <= r_skidMask & ~w_clrMask;
        r_outPkt    <= r_skidPkt;
        r_skidValid <= 1'b0;
      end else begin
        r_outValid <= w_inValid;
        if (w_inValid) begin
          r_outMask <= w_inMask;
          r_outPkt  <= w_inPkt;
        end
      end
    end else begin
      // Output is valid, not squashed, and stalled: hold payload.
      r_outMask <= r_outMask & ~w_clrMask;
      if (r_skidValid) begin
        r_skidValid <= ~w_skidKill;
        r_skidMask  <= r_skidMask & ~w_clrMask;
      end else if (w_inValid) begin
        r_skidValid <= 1'b1;
        r_skidMask  <= w_inMask;
        r_skidPkt   <= w_inPkt;
      end
    end
  end

  assign agenMask_o = r_outMask;
  assign {agenType_o, agenAddr_o, agenStData_o, agenLsqId_o, agenAlId_o,
          agenPhyDest_o, agenMisalign_o} = r_outPkt;

endmodule
`default_nettype wire

// File: tb/tb_agen_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_agen_stage
// Purpose  : Directed self-checking bench for agen_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_agen_stage;

`ifdef AGEN_MISALIGN_TRAP_EN
  localparam logic MIS_ON = 1'b1;
`else
  localparam logic MIS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrlMispredict, ctrlResolve;
  logic [2:0]  ctrlSMTid;
  logic        issueValid, issueReady;
  logic [7:0]  issueMask;
  logic [2:0]  issueType;
  logic [31:0] issueBase, issueStData;
  logic [15:0] issueImm;
  logic [4:0]  issueLsqId;
  logic [6:0]  issueAlId, issuePhyDest;
  logic        lsuReady;
  logic        agenValid, agenMisalign;
  logic [7:0]  agenMask;
  logic [2:0]  agenType;
  logic [31:0] agenAddr, agenStData;
  logic [4:0]  agenLsqId;
  logic [6:0]  agenAlId, agenPhyDest;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  agen_stage dut (
    .clk(clk), .reset(reset),
    .ctrlMispredict_i(ctrlMispredict), .ctrlResolve_i(ctrlResolve),
    .ctrlSMTid_i(ctrlSMTid),
    .issueValid_i(issueValid), .issueReady_o(issueReady),
    .issueMask_i(issueMask), .issueType_i(issueType),
    .issueBase_i(issueBase), .issueImm_i(issueImm),
    .issueStData_i(issueStData), .issueLsqId_i(issueLsqId),
    .issueAlId_i(issueAlId), .issuePhyDest_i(issuePhyDest),
    .lsuReady_i(lsuReady),
    .agenValid_o(agenValid), .agenMask_o(agenMask), .agenType_o(agenType),
    .agenAddr_o(agenAddr), .agenStData_o(agenStData),
    .agenLsqId_o(agenLsqId), .agenAlId_o(agenAlId),
    .agenPhyDest_o(agenPhyDest), .agenMisalign_o(agenMisalign)
  );

  task automatic checkVal(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for one clock edge, then withdraws it.
  task automatic issueOp(input logic [31:0] base, input logic [15:0] imm,
                         input logic [2:0] typ, input logic [7:0] mask,
                         input logic [31:0] stData);
    issueBase   = base;
    issueImm    = imm;
    issueType   = typ;
    issueMask   = mask;
    issueStData = stData;
    issueValid  = 1'b1;
    step();
    issueValid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ctrlMispredict = 0; ctrlResolve = 0; ctrlSMTid = 0;
    issueValid = 0; issueMask = 0; issueType = 0; issueBase = 0;
    issueImm = 0; issueStData = 0; issueLsqId = 5'd3; issueAlId = 7'd9;
    issuePhyDest = 7'd17; lsuReady = 1'b1;
    step(); step();
    reset = 1'b0;
    checkVal("rst_valid", agenValid, 0);
    checkVal("rst_addr", agenAddr, 0);
    checkVal("rst_mask", agenMask, 0);
    checkVal("rst_ready", issueReady, 1);

    // Word load with negative offset
    issueOp(32'h0000_1000, 16'hFFFC, 3'd2, 8'h00, 32'h0);
    checkVal("ld_valid", agenValid, 1);
    checkVal("ld_addr", agenAddr, 32'h0000_0FFC);
    checkVal("ld_mis", agenMisalign, 0);
    checkVal("ld_ids", {agenLsqId, agenAlId, agenPhyDest}, {5'd3, 7'd9, 7'd17});

    // Halfword with address wrap-around
    issueOp(32'hFFFF_FFFE, 16'h0004, 3'd1, 8'h00, 32'h0);
    checkVal("wrap_addr", agenAddr, 32'h0000_0002);
    checkVal("wrap_mis", agenMisalign, 0);
    issueOp(32'hFFFF_FFFE, 16'h0003, 3'd5, 8'h00, 32'hCAFE);
    checkVal("odd_addr", agenAddr, 32'h0000_0001);
    checkVal("odd_mis", agenMisalign, MIS_ON);
    checkVal("odd_type", agenType, 3'd5);
    checkVal("odd_st", agenStData, 32'hCAFE);
    issueOp(32'h0000_0000, 16'h0000, 3'd3, 8'h00, 32'h0);
    checkVal("rsv_mis", agenMisalign, MIS_ON);
    issueOp(32'h0000_0003, 16'h0000, 3'd0, 8'h00, 32'h0);
    checkVal("byte_mis", agenMisalign, 0);
    step();
    checkVal("drain_valid", agenValid, 0);

    // Backpressure: A held, B parked in skid, both delivered in order
    lsuReady = 1'b0;
    issueOp(32'h0000_0100, 16'h0000, 3'd2, 8'h00, 32'hA);
    checkVal("stall_A_ready", issueReady, 1);
    issueOp(32'h0000_0200, 16'h0000, 3'd2, 8'h00, 32'hB);
    checkVal("stall_A_valid", agenValid, 1);
    checkVal("stall_A_addr", agenAddr, 32'h100);
    checkVal("stall_ready0", issueReady, 0);
    step();
    checkVal("stall_A_hold", agenAddr, 32'h100);
    checkVal("stall_A_st", agenStData, 32'hA);
    checkVal("stall_ready0b", issueReady, 0);
    lsuReady = 1'b1;
    #1;
    checkVal("rel_A_valid", agenValid, 1);
    checkVal("rel_A_addr", agenAddr, 32'h100);
    step();
    checkVal("rel_B_valid", agenValid, 1);
    checkVal("rel_B_addr", agenAddr, 32'h200);
    checkVal("rel_B_st", agenStData, 32'hB);
    checkVal("rel_ready", issueReady, 1);
    step();
    checkVal("rel_empty", agenValid, 0);

    // Mispredict kills stalled output, skid entry survives
    lsuReady = 1'b0;
    issueOp(32'h0000_0300, 16'h0000, 3'd2, 8'h04, 32'h0);
    issueOp(32'h0000_0400, 16'h0000, 3'd2, 8'h01, 32'h0);
    ctrlMispredict = 1'b1; ctrlSMTid = 3'd2;
    #1;
    checkVal("mp_same_cycle", agenValid, 0);
    step();
    ctrlMispredict = 1'b0;
    checkVal("mp_skid_valid", agenValid, 1);
    checkVal("mp_skid_mask", agenMask, 8'h01);
    checkVal("mp_skid_addr", agenAddr, 32'h400);
    lsuReady = 1'b1;
    step();
    checkVal("mp_empty", agenValid, 0);

    // Mispredict squashes an incoming packet
    ctrlMispredict = 1'b1; ctrlSMTid = 3'd3;
    issueOp(32'h0000_0500, 16'h0000, 3'd2, 8'h08, 32'h0);
    ctrlMispredict = 1'b0;
    checkVal("mp_in_kill", agenValid, 0);

    // Resolve clears mask bit on held output
    lsuReady = 1'b0;
    issueOp(32'h0000_0600, 16'h0000, 3'd2, 8'h03, 32'h0);
    checkVal("res_pre", agenMask, 8'h03);
    ctrlResolve = 1'b1; ctrlSMTid = 3'd0;
    step();
    ctrlResolve = 1'b0;
    checkVal("res_mask", agenMask, 8'h02);
    checkVal("res_valid", agenValid, 1);
    ctrlResolve = 1'b1; ctrlMispredict = 1'b1; ctrlSMTid = 3'd1;
    #1;
    checkVal("mpres_same", agenValid, 0);
    step();
    ctrlResolve = 1'b0; ctrlMispredict = 1'b0;
    checkVal("mpres_kill", agenValid, 0);

    // Resolve applied to the incoming packet before capture
    lsuReady = 1'b1;
    ctrlResolve = 1'b1; ctrlSMTid = 3'd0;
    issueOp(32'h0000_0700, 16'h0000, 3'd2, 8'h11, 32'h0);
    ctrlResolve = 1'b0;
    checkVal("res_in_mask", agenMask, 8'h10);
    step();

    // Reset with full skid and stalled output
    lsuReady = 1'b0;
    issueOp(32'h0000_0800, 16'h0000, 3'd2, 8'h00, 32'h0);
    issueOp(32'h0000_0900, 16'h0000, 3'd2, 8'h00, 32'h0);
    checkVal("rst2_pre_ready", issueReady, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkVal("rst2_valid", agenValid, 0);
    checkVal("rst2_ready", issueReady, 1);
    lsuReady = 1'b1;
    step();
    checkVal("rst2_skid_gone", agenValid, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
`default_nettype wire
